// File: rtl/regfile_mp_sb_if.sv
// Register file port bundle: read, write and scoreboard-allocate ports.
// master = issue/writeback side, slave = the register file itself.
interface regfile_mp_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic [NREGS-1:0]    busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data,
        output alloc_en, alloc_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data,
        input  alloc_en, alloc_addr,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with per-register busy scoreboard.
// Ports: clk, rst (async active-low), bus (regfile_mp_sb_if.slave):
//   NRD combinational read ports with busy, NWR write ports
//   (highest index wins), one allocate port, full busy_vec view.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through on reads.
module regfile_mp_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input  logic           clk,
    input  logic           rst,
    regfile_mp_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  arf [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] wr_hit;
    logic [NREGS-1:0] alloc_hit;
    logic [AW-1:0]    ra;
    logic [XLEN-1:0]  rv;

    // Decode write and alloc targets into one-hot register masks.
    always_comb begin
        wr_hit    = '0;
        alloc_hit = '0;
        for (int w = 0; w < NWR; w++) begin
            if (bus.wr_en[w])
                wr_hit[bus.wr_addr[w*AW +: AW]] = 1'b1;
        end
        if (bus.alloc_en)
            alloc_hit[bus.alloc_addr] = 1'b1;
    end

    // Later loop iterations override earlier ones, so the
    // highest-index port wins on an address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++)
                arf[i] <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (bus.wr_en[w] &&
                    bus.wr_addr[w*AW +: AW] != '0)
                    arf[bus.wr_addr[w*AW +: AW]] <=
                        bus.wr_data[w*XLEN +: XLEN];
            end
        end
    end

    // Alloc beats a retiring write: the new producer is still pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int i = 1; i < NREGS; i++) begin
                if (alloc_hit[i])
                    busy[i] <= 1'b1;
                else if (wr_hit[i])
                    busy[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        ra          = '0;
        rv          = '0;
        for (int p = 0; p < NRD; p++) begin
            ra = bus.rd_addr[p*AW +: AW];
            rv = arf[ra];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NWR; w++) begin
                if (bus.wr_en[w] &&
                    bus.wr_addr[w*AW +: AW] == ra)
                    rv = bus.wr_data[w*XLEN +: XLEN];
            end
`endif
            if (ra == '0)
                rv = '0;
            bus.rd_data[p*XLEN +: XLEN] = rv;
            bus.rd_busy[p]              = busy[ra];
        end
    end

    assign bus.busy_vec = busy;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb (default 32x32, 2R/2W).
// Directed vector table, hand sequences and a random model sweep.
module tb_regfile_mp_sb;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    regfile_mp_sb_if #(
        .XLEN(32), .NREGS(32), .NRD(2), .NWR(2)
    ) bus ();

    regfile_mp_sb #(
        .XLEN(32), .NREGS(32), .NRD(2), .NWR(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        ae;
        logic [4:0]  aa;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
        logic [31:0] bv;
    } vec_t;

    vec_t vt[10];

    logic [31:0] mreg [32];
    logic [31:0] mbusy;

    task automatic chk(string name, logic [31:0] act,
                       logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en    = '0;
        bus.alloc_en = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        bus.rd_addr    = '0;
        bus.wr_en      = '0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.alloc_en   = 1'b0;
        bus.alloc_addr = '0;

        vt[0] = '{2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'h0,
                  1'b1, 5'd0, 5'd0, 5'd0,
                  32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        vt[1] = '{2'b11, 5'd5, 32'h1111, 5'd5, 32'h2222,
                  1'b0, 5'd0, 5'd5, 5'd0,
                  32'h2222, 32'h0, 1'b0, 1'b0, 32'h0};
        vt[2] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0,
                  1'b1, 5'd7, 5'd7, 5'd5,
                  32'h0, 32'h2222, 1'b1, 1'b0, 32'h80};
        vt[3] = '{2'b01, 5'd7, 32'h55, 5'd0, 32'h0,
                  1'b0, 5'd0, 5'd7, 5'd5,
                  32'h55, 32'h2222, 1'b0, 1'b0, 32'h0};
        vt[4] = '{2'b01, 5'd7, 32'h55, 5'd0, 32'h0,
                  1'b1, 5'd7, 5'd7, 5'd0,
                  32'h55, 32'h0, 1'b1, 1'b0, 32'h80};
        vt[5] = '{2'b01, 5'd9, 32'hABC, 5'd0, 32'h0,
                  1'b1, 5'd7, 5'd9, 5'd7,
                  32'hABC, 32'h55, 1'b0, 1'b1, 32'h80};
        vt[6] = '{2'b10, 5'd0, 32'h0, 5'd7, 32'h77,
                  1'b0, 5'd0, 5'd7, 5'd9,
                  32'h77, 32'hABC, 1'b0, 1'b0, 32'h0};
        vt[7] = '{2'b11, 5'd31, 32'hFFFFFFFF,
                  5'd30, 32'h12345678,
                  1'b1, 5'd31, 5'd31, 5'd30,
                  32'hFFFFFFFF, 32'h12345678,
                  1'b1, 1'b0, 32'h80000000};
        vt[8] = '{2'b11, 5'd31, 32'h1, 5'd31, 32'h2,
                  1'b0, 5'd0, 5'd31, 5'd30,
                  32'h2, 32'h12345678, 1'b0, 1'b0, 32'h0};
        vt[9] = '{2'b01, 5'd1, 32'hA, 5'd1, 32'hB,
                  1'b0, 5'd0, 5'd1, 5'd1,
                  32'hA, 32'hA, 1'b0, 1'b0, 32'h0};

        // Reset state while rst is held low.
        bus.rd_addr = {5'd5, 5'd31};
        #1;
        chk("rst_rd_data", bus.rd_data[31:0], 32'h0);
        chk("rst_busy_vec", bus.busy_vec, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            bus.wr_en      = vt[i].we;
            bus.wr_addr    = {vt[i].wa1, vt[i].wa0};
            bus.wr_data    = {vt[i].wd1, vt[i].wd0};
            bus.alloc_en   = vt[i].ae;
            bus.alloc_addr = vt[i].aa;
            cyc();
            idle();
            bus.rd_addr = {vt[i].ra1, vt[i].ra0};
            #1;
            chk($sformatf("v%0d_d0", i),
                bus.rd_data[31:0], vt[i].d0);
            chk($sformatf("v%0d_d1", i),
                bus.rd_data[63:32], vt[i].d1);
            chk($sformatf("v%0d_b0", i),
                {31'b0, bus.rd_busy[0]}, {31'b0, vt[i].b0});
            chk($sformatf("v%0d_b1", i),
                {31'b0, bus.rd_busy[1]}, {31'b0, vt[i].b1});
            chk($sformatf("v%0d_bv", i),
                bus.busy_vec, vt[i].bv);
        end

        // Same-cycle read of a write target (r3 still 0).
        cyc();
        bus.wr_en   = 2'b01;
        bus.wr_addr = {5'd0, 5'd3};
        bus.wr_data = {32'h0, 32'hCAFE};
        bus.rd_addr = {5'd3, 5'd3};
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_same", bus.rd_data[31:0], 32'hCAFE);
`else
        chk("byp_same", bus.rd_data[31:0], 32'h0);
`endif
        cyc();
        idle();
        #1;
        chk("byp_next", bus.rd_data[63:32], 32'hCAFE);

        // Mid-cycle async reset, with writes pending across it.
        bus.wr_en      = 2'b01;
        bus.wr_addr    = {5'd0, 5'd9};
        bus.wr_data    = {32'h0, 32'h5};
        bus.alloc_en   = 1'b1;
        bus.alloc_addr = 5'd9;
        cyc();
        idle();
        bus.rd_addr = {5'd3, 5'd9};
        #2;
        chk("pre_rst_r9", bus.rd_data[31:0], 32'h5);
        bus.wr_en   = 2'b01;
        bus.wr_data = {32'h0, 32'h7};
        rst = 1'b0;
        #1;
        chk("mid_rst_d0", bus.rd_data[31:0], 32'h0);
        chk("mid_rst_d1", bus.rd_data[63:32], 32'h0);
        chk("mid_rst_b0", {31'b0, bus.rd_busy[0]}, 32'h0);
        chk("mid_rst_bv", bus.busy_vec, 32'h0);
        cyc();
        rst = 1'b1;
        idle();
        cyc();
        #1;
        chk("post_rst_r9", bus.rd_data[31:0], 32'h0);

        // Random sweep against a reference model.
        for (int i = 0; i < 32; i++)
            mreg[i] = '0;
        mbusy = '0;
        for (int n = 0; n < 2000; n++) begin
            logic [1:0]  we;
            logic [4:0]  wa [2];
            logic [31:0] wd [2];
            logic [4:0]  ra [2];
            logic        ae;
            logic [4:0]  aa;
            logic [31:0] e;
            we    = 2'($urandom_range(0, 3));
            wa[0] = 5'($urandom_range(0, 7));
            wa[1] = 5'($urandom_range(0, 7));
            wd[0] = $urandom;
            wd[1] = $urandom;
            ra[0] = 5'($urandom_range(0, 7));
            ra[1] = 5'($urandom_range(0, 31));
            ae    = 1'($urandom_range(0, 1));
            aa    = 5'($urandom_range(0, 7));
            bus.wr_en      = we;
            bus.wr_addr    = {wa[1], wa[0]};
            bus.wr_data    = {wd[1], wd[0]};
            bus.rd_addr    = {ra[1], ra[0]};
            bus.alloc_en   = ae;
            bus.alloc_addr = aa;
            #1;
            for (int p = 0; p < 2; p++) begin
                e = mreg[ra[p]];
`ifdef REGFILE_BYPASS_EN
                for (int w = 0; w < 2; w++)
                    if (we[w] && wa[w] == ra[p]) e = wd[w];
`endif
                if (ra[p] == 5'd0) e = '0;
                chk($sformatf("rnd%0d_d%0d", n, p),
                    bus.rd_data[p*32 +: 32], e);
                chk($sformatf("rnd%0d_b%0d", n, p),
                    {31'b0, bus.rd_busy[p]},
                    {31'b0, mbusy[ra[p]]});
            end
            chk($sformatf("rnd%0d_bv", n),
                bus.busy_vec, mbusy);
            for (int w = 0; w < 2; w++) begin
                if (we[w] && wa[w] != 5'd0) begin
                    mreg[wa[w]]  = wd[w];
                    mbusy[wa[w]] = 1'b0;
                end
            end
            if (ae && aa != 5'd0)
                mbusy[aa] = 1'b1;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end
endmodule
